// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: captures a single-cycle snapshot of REG_COUNT register words
// and streams them out one word per beat over a valid/ready handshake.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends a final beat carrying the
// XOR of all captured words (dump becomes REG_COUNT+1 beats).
module reg_dump_streamer #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned WIDTH     = 32,
  localparam int unsigned IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REG_COUNT*WIDTH-1:0] reg_flat,
  input  logic                       snap_req,
  output logic                       snap_busy,
  output logic                       snap_drop,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [WIDTH-1:0]           dump_data,
  output logic [IDX_W-1:0]           dump_index,
  output logic                       dump_last,
  output logic [7:0]                 drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM
`ifdef REG_DUMP_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_buf [REG_COUNT];
  logic             r_valid;
  logic             r_busy;
  logic             r_drop;
  logic [7:0]       r_drop_cnt;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_index;
  logic             r_last;

  logic             w_capture;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_capture = (r_state == S_IDLE) && snap_req;
  assign w_idx_nxt = r_index + IDX_W'(1);

`ifdef REG_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] w_xor;

  // XOR reduction over the captured snapshot for the trailing checksum beat
  always_comb begin
    w_xor = '0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      w_xor = w_xor ^ r_buf[k];
    end
  end
`endif

  // Snapshot buffer: written only on an accepted capture, contents unreset
  always_ff @(posedge clock) begin
    if (w_capture) begin
      for (int unsigned k = 0; k < REG_COUNT; k++) begin
        r_buf[k] <= reg_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  // Control FSM with registered stream outputs and drop accounting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
      r_data     <= '0;
      r_index    <= '0;
      r_last     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (snap_req && (r_state != S_IDLE)) begin
        r_drop <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            // Beat 0 is taken straight from the input so it shows the cycle after capture
            r_state <= S_STREAM;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_data  <= reg_flat[WIDTH-1:0];
            r_index <= '0;
            r_last  <= !CKSUM_ON && (REG_COUNT == 1);
          end
        end

        S_STREAM: begin
          if (dump_ready) begin
            if (r_index == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              r_state <= S_CKSUM;
              r_data  <= w_xor;
              r_index <= '0;
              r_last  <= 1'b1;
`else
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_data  <= '0;
              r_index <= '0;
              r_last  <= 1'b0;
`endif
            end else begin
              r_index <= w_idx_nxt;
              r_data  <= r_buf[w_idx_nxt];
              r_last  <= !CKSUM_ON && (w_idx_nxt == LAST_IDX);
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        S_CKSUM: begin
          if (dump_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_data  <= '0;
          r_index <= '0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign snap_busy  = r_busy;
  assign snap_drop  = r_drop;
  assign dump_valid = r_valid;
  assign dump_data  = r_data;
  assign dump_index = r_index;
  assign dump_last  = r_last;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Testbench for reg_dump_streamer: scoreboard of expected beats filled at capture
// time, checked by an independent monitor on the falling edge.
module tb_reg_dump_streamer;

  localparam int unsigned RC = 32;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit          CKS    = 1'b1;
  localparam int unsigned NBEATS = RC + 1;
`else
  localparam bit          CKS    = 1'b0;
  localparam int unsigned NBEATS = RC;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [RC*W-1:0] reg_flat;
  logic          snap_req;
  logic          snap_busy;
  logic          snap_drop;
  logic          dump_valid;
  logic          dump_ready = 1'b1;
  logic [W-1:0]  dump_data;
  logic [IW-1:0] dump_index;
  logic          dump_last;
  logic [7:0]    drop_count;

  reg_dump_streamer #(.REG_COUNT(RC), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .reg_flat   (reg_flat),
    .snap_req   (snap_req),
    .snap_busy  (snap_busy),
    .snap_drop  (snap_drop),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_last  (dump_last),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  beat_t       q[$];
  beat_t       exp_b;
  beat_t       held;
  logic        hold_pend = 1'b0;
  logic [W-1:0] cur_words [RC];
  int          checks = 0;
  int          passes = 0;
  int          beats_acc = 0;
  int          drop_pulses = 0;
  int          model_drops = 0;
  int          ready_mode = 1; // 0 low, 1 high, 2 random, 3 toggle

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Ready driver
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       dump_ready = 1'b0;
      1:       dump_ready = 1'b1;
      2:       dump_ready = 1'($urandom_range(0, 1));
      default: dump_ready = ~dump_ready;
    endcase
  end

  // Monitor: pops expected beats on handshakes, checks stability under backpressure
  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (snap_drop) drop_pulses++;
      if (hold_pend) begin
        chk("valid_held", {63'd0, dump_valid}, 64'd1);
        if (dump_valid) chk("hold_stable", {dump_data, dump_index, dump_last}, held);
      end
      hold_pend = 1'b0;
      if (dump_valid) begin
        if (dump_ready) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got idx %0d data %0h, expected no beat", dump_index, dump_data);
          end else begin
            exp_b = q.pop_front();
            chk("beat", {dump_data, dump_index, dump_last}, exp_b);
            beats_acc++;
          end
        end else begin
          hold_pend = 1'b1;
          held = {dump_data, dump_index, dump_last};
        end
      end
    end
  end

  // Reference model: a dump is the captured words in order, then optionally their XOR
  task automatic push_dump();
    beat_t        b;
    logic [W-1:0] x;
    x = '0;
    for (int k = 0; k < RC; k++) begin
      b.d = cur_words[k];
      b.i = IW'(k);
      b.l = !CKS && (k == RC - 1);
      q.push_back(b);
      x = x ^ cur_words[k];
    end
    if (CKS) begin
      b.d = x;
      b.i = '0;
      b.l = 1'b1;
      q.push_back(b);
    end
  endtask

  task automatic add_drops(input int n);
    model_drops = (model_drops + n > 255) ? 255 : model_drops + n;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, {63'd0, dump_valid}, 64'd0);
    chk({name, "_busy"},  {63'd0, snap_busy},  64'd0);
    chk({name, "_drop"},  {63'd0, snap_drop},  64'd0);
    chk({name, "_data"},  {32'd0, dump_data},  64'd0);
    chk({name, "_index"}, {59'd0, dump_index}, 64'd0);
    chk({name, "_last"},  {63'd0, dump_last},  64'd0);
    chk({name, "_dcnt"},  {56'd0, drop_count}, 64'd0);
  endtask

  // Called at posedge+1 with the DUT idle; request is sampled at the next edge
  task automatic start_dump();
    for (int k = 0; k < RC; k++) reg_flat[k*W +: W] = cur_words[k];
    snap_req = 1'b1;
    push_dump();
    @(posedge clock); #1;
    snap_req = 1'b0;
    chk("first_vb", {62'd0, dump_valid, snap_busy}, 64'd3);
    chk("first_index", {59'd0, dump_index}, 64'd0);
    for (int k = 0; k < RC; k++) reg_flat[k*W +: W] = 32'hDEAD_BEEF;
  endtask

  task automatic wait_empty(input string name, output int n);
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    chk({name, "_drained"}, {63'd0, q.size() == 0}, 64'd1);
    q.delete();
  endtask

  task automatic finish_dump(input string name);
    int n;
    wait_empty(name, n);
    @(posedge clock); #1;
    chk({name, "_idle"}, {62'd0, snap_busy, dump_valid}, 64'd0);
  endtask

  task automatic wait_beats(input string name, input int target);
    int n;
    n = 0;
    while (beats_acc < target && n < 500) begin
      @(negedge clock); #1;
      n++;
    end
    chk({name, "_reached"}, {63'd0, beats_acc >= target}, 64'd1);
  endtask

  task automatic rand_words();
    for (int k = 0; k < RC; k++) cur_words[k] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int p0;
    reset    = 1'b1;
    snap_req = 1'b0;
    reg_flat = '0;
    #12;
    chk_reset_outputs("rst0");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic dump at full throughput
    ready_mode = 1;
    for (int k = 0; k < RC; k++) cur_words[k] = 32'h1000_0000 + k;
    start_dump();
    wait_empty("basic", n);
    chk("basic_cycles", 64'(n), 64'(NBEATS));
    @(posedge clock); #1;
    chk("basic_idle", {62'd0, snap_busy, dump_valid}, 64'd0);

    // Toggling backpressure
    ready_mode = 3;
    rand_words();
    base = beats_acc;
    start_dump();
    finish_dump("toggle");
    chk("toggle_count", 64'(beats_acc - base), 64'(NBEATS));

    // Random backpressure, back-to-back dumps
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      rand_words();
      start_dump();
      finish_dump("random");
    end

    // Checksum pattern
    ready_mode = 1;
    for (int k = 0; k < RC; k++) cur_words[k] = 32'(k) * 32'h0101_0101;
    start_dump();
    finish_dump("cksum_pat");

    // Drop: three requests while beat 5 is held
    rand_words();
    base = beats_acc;
    start_dump();
    wait_beats("drop_b5", base + 5);
    ready_mode = 0;
    @(posedge clock); #1;
    p0 = drop_pulses;
    repeat (3) begin
      snap_req = 1'b1;
      @(posedge clock); #1;
    end
    snap_req = 1'b0;
    add_drops(3);
    repeat (2) @(posedge clock);
    #1;
    chk("drop_pulses3", 64'(drop_pulses - p0), 64'd3);
    chk("drop_count3", {56'd0, drop_count}, 64'(model_drops));
    ready_mode = 1;
    finish_dump("drop");

    // Saturation: 300 requests while stalled
    rand_words();
    start_dump();
    ready_mode = 0;
    p0 = drop_pulses;
    repeat (300) begin
      snap_req = 1'b1;
      @(posedge clock); #1;
    end
    snap_req = 1'b0;
    add_drops(300);
    repeat (2) @(posedge clock);
    #1;
    chk("drop_pulses300", 64'(drop_pulses - p0), 64'd300);
    chk("drop_sat", {56'd0, drop_count}, 64'(model_drops));
    ready_mode = 2;
    finish_dump("sat");

    // Reset mid-dump at beat 10
    ready_mode = 1;
    rand_words();
    base = beats_acc;
    start_dump();
    wait_beats("rst_b10", base + 10);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    q.delete();
    model_drops = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_idle", {62'd0, snap_busy, dump_valid}, 64'd0);

    // Clean restart after reset
    ready_mode = 2;
    rand_words();
    start_dump();
    finish_dump("restart");
    chk("final_dcnt", {56'd0, drop_count}, 64'(model_drops));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
